// File: rtl/faccel_host.sv
// Bus initiator for the factorial accelerator: writes N, pulses GO, polls STATUS,
// reads RESULT and hands it back with a one-cycle done pulse (or a timeout pulse).
module faccel_host #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        start,
  input  logic [3:0]  n_in,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        ovf,
  output logic [31:0] result,
  output logic        we,
  output logic [1:0]  a,
  output logic [3:0]  d,
  input  logic [31:0] rd
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_N   = 3'd1,
    S_WR_GO  = 3'd2,
    S_CLR_GO = 3'd3,
    S_POLL   = 3'd4,
    S_RD_RES = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_n;
  logic [CW-1:0]   r_cnt;
  logic            r_to;
  logic            r_ovf;
  logic [31:0]     r_result;
  logic            w_expire;

  assign w_expire = (r_cnt == LP_LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_WR_N;
      S_WR_N:   w_next = S_WR_GO;
      S_WR_GO:  w_next = S_CLR_GO;
      S_CLR_GO: w_next = S_POLL;
      S_POLL: begin
        if (rd[0])         w_next = S_RD_RES;
        else if (w_expire) w_next = S_DONE;
      end
      S_RD_RES: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus and status outputs are pure decodes of the state register
  always_comb begin
    we      = 1'b0;
    a       = 2'd0;
    d       = 4'd0;
    busy    = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    unique case (r_state)
      S_WR_N:   begin we = 1'b1; a = 2'd0; d = r_n;     busy = 1'b1; end
      S_WR_GO:  begin we = 1'b1; a = 2'd1; d = 4'b0001; busy = 1'b1; end
      S_CLR_GO: begin we = 1'b1; a = 2'd1; d = 4'b0000; busy = 1'b1; end
      S_POLL:   begin a = 2'd2; busy = 1'b1; end
      S_RD_RES: begin a = 2'd3; busy = 1'b1; end
      S_DONE:   begin done = 1'b1; timeout = r_to; end
      default:  begin end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_n      <= 4'd0;
      r_cnt    <= '0;
      r_to     <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n   <= n_in;
            r_ovf <= (n_in > 4'd12);
            r_cnt <= '0;
            r_to  <= 1'b0;
          end
        end
        S_POLL: begin
          if (!rd[0]) begin
            if (w_expire) begin
              r_result <= 32'd0;
              r_to     <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_RD_RES: r_result <= rd;
        default: begin end
      endcase
    end
  end

  assign ovf    = r_ovf;
  assign result = r_result;

endmodule

// File: tb/tb_faccel_host.sv
// Directed and randomized jobs for faccel_host against a behavioural accelerator
// with configurable completion latency or a stuck-at-0 STATUS.
module tb_faccel_host;

  localparam int TO = 8;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [3:0]  n_in;
  logic        busy, done, timeout, ovf;
  logic [31:0] result;
  logic        we;
  logic [1:0]  a;
  logic [3:0]  d;
  logic [31:0] rd;

  int n_vec = 0;
  int n_err = 0;

  int          acc_lat   = 0;
  bit          acc_stuck = 1'b0;
  logic [3:0]  acc_n     = 4'd0;
  logic [31:0] acc_res   = 32'd0;
  int          acc_cnt   = 0;

  faccel_host #(.TIMEOUT(TO), .CW(4)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .n_in(n_in),
    .busy(busy), .done(done), .timeout(timeout), .ovf(ovf), .result(result),
    .we(we), .a(a), .d(d), .rd(rd)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] p = 32'd1;
    for (int k = 2; k <= int'(n); k++) p = p * 32'(k);
    return p;
  endfunction

  // Accelerator: GO=1 write captures n! and completes acc_lat cycles later
  always @(posedge Clk) begin
    if (we && a == 2'd0) acc_n <= d;
    if (we && a == 2'd1 && d[0]) begin
      acc_res <= fact(acc_n);
      acc_cnt <= acc_lat;
    end else if (acc_cnt > 0) begin
      acc_cnt <= acc_cnt - 1;
    end
  end

  assign rd = (a == 2'd2) ? (32'hA5A5_0000 | {31'd0, (acc_cnt == 0) && !acc_stuck}) :
              (a == 2'd3) ? acc_res : 32'd0;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called with the DUT sampled in its WR_N cycle; returns sampled in the DONE cycle
  task automatic finish_job(input logic [3:0] n, input int exp_polls, input bit exp_to,
                            input bit disturb);
    int polls;
    chk("wrn_we", 32'(we), 32'd1);
    chk("wrn_a", 32'(a), 32'd0);
    chk("wrn_d", 32'(d), 32'(n));
    chk("wrn_busy", 32'(busy), 32'd1);
    chk("ovf_accept", 32'(ovf), 32'(n > 4'd12));
    tick;
    chk("go_bus", {28'd0, we, a, 1'b0}, {28'd0, 1'b1, 2'd1, 1'b0});
    chk("go_d", 32'(d), 32'd1);
    tick;
    chk("clr_bus", {28'd0, we, a, 1'b0}, {28'd0, 1'b1, 2'd1, 1'b0});
    chk("clr_d", 32'(d), 32'd0);
    tick;
    polls = 0;
    while (we == 1'b0 && a == 2'd2 && polls < TO + 2) begin
      polls++;
      if (disturb && polls == 1) begin
        start = 1'b1;
        n_in  = ~n;
      end
      tick;
      start = 1'b0;
      n_in  = n;
    end
    chk("poll_count", 32'(polls), 32'(exp_polls));
    if (!exp_to) begin
      chk("rdres_a", 32'(a), 32'd3);
      chk("rdres_busy", 32'(busy), 32'd1);
      tick;
    end
    chk("done", 32'(done), 32'd1);
    chk("timeout", 32'(timeout), 32'(exp_to));
    chk("done_busy", 32'(busy), 32'd0);
    chk("result", result, exp_to ? 32'd0 : fact(n));
    chk("ovf_done", 32'(ovf), 32'(n > 4'd12));
  endtask

  task automatic run_job(input logic [3:0] n, input int lat, input bit stuck, input bit disturb);
    acc_lat   = lat;
    acc_stuck = stuck;
    start     = 1'b1;
    n_in      = n;
    tick;
    start = 1'b0;
    finish_job(n, stuck ? TO : ((lat == 0) ? 1 : lat), stuck, disturb);
    tick;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    acc_stuck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b1; start = 1'b0; n_in = 4'd0;
    tick;
    tick;
    chk("rst_bus", {25'd0, we, a, d}, 32'd0);
    chk("rst_flags", {28'd0, busy, done, timeout, ovf}, 32'd0);
    chk("rst_result", result, 32'd0);
    Rst = 1'b0;
    tick;

    run_job(4'd5, 2, 1'b0, 1'b0);
    run_job(4'd0, 0, 1'b0, 1'b0);
    run_job(4'd1, 1, 1'b0, 1'b0);
    run_job(4'd12, 3, 1'b0, 1'b0);
    run_job(4'd13, 1, 1'b0, 1'b0);
    tick;
    chk("ovf_hold", 32'(ovf), 32'd1);
    run_job(4'd3, 4, 1'b0, 1'b0);

    // STATUS stuck low: timeout path
    run_job(4'd9, 0, 1'b1, 1'b0);

    // start pulsed during POLL is ignored
    run_job(4'd6, 3, 1'b0, 1'b1);

    // start held through DONE launches the next job after one idle cycle
    acc_lat = 2;
    start = 1'b1; n_in = 4'd7;
    tick;
    start = 1'b0;
    finish_job(4'd7, 2, 1'b0, 1'b0);
    start = 1'b1; n_in = 4'd10;
    tick;
    chk("held_idle", {28'd0, busy, done, we, 1'b0}, 32'd0);
    tick;
    start = 1'b0;
    finish_job(4'd10, 2, 1'b0, 1'b0);
    tick;

    // reset in the second POLL cycle
    acc_lat = 5;
    start = 1'b1; n_in = 4'd7;
    tick;
    start = 1'b0;
    tick; tick; tick; tick;
    chk("rst_mid_poll_a", 32'(a), 32'd2);
    Rst = 1'b1;
    tick;
    Rst = 1'b0;
    chk("rst_mid_bus", {29'd0, we, a}, 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    run_job(4'd4, 1, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_job(4'($urandom_range(0, 15)), int'($urandom_range(0, 5)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
